// File: rtl/counter_nbit_if.sv
// Control and status bundle for counter_nbit: the bench drives the master side,
// the counter sits on the slave side.
interface counter_nbit_if #(
  parameter int unsigned WIDTH = 3
);
  logic             sclr;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             wrap;

  modport master (
    output sclr, load, din, en, up,
    input  q, qbar, tc, wrap
  );

  modport slave (
    input  sclr, load, din, en, up,
    output q, qbar, tc, wrap
  );
endinterface

// File: rtl/counter_nbit.sv
// Modulo-MODULUS up/down counter with synchronous clear, saturating parallel
// load, combinational terminal count and a registered wrap pulse.
module counter_nbit #(
  parameter int unsigned      WIDTH   = 3,
  parameter longint unsigned  MODULUS = 64'd1 << WIDTH
) (
  input  logic          clk,
  input  logic          clr,
  counter_nbit_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] q_nxt;
  logic             tc_c;

  // Terminal count: the step taken on this edge will wrap.
  always_comb begin
    tc_c = 1'b0;
    if (bus.en && !bus.sclr && !bus.load) begin
      tc_c = bus.up ? (bus.q == MAX) : (bus.q == '0);
    end
  end

  // Next count, priority sclr > load > en > hold; all arithmetic stays in 0..MAX.
  always_comb begin
    q_nxt = bus.q;
    if (bus.sclr) begin
      q_nxt = '0;
    end else if (bus.load) begin
      q_nxt = (bus.din > MAX) ? MAX : bus.din;
    end else if (bus.en) begin
      if (bus.up) begin
        q_nxt = (bus.q == MAX) ? '0 : bus.q + WIDTH'(1);
      end else begin
        q_nxt = (bus.q == '0) ? MAX : bus.q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bus.q    <= '0;
      bus.wrap <= 1'b0;
    end else begin
      bus.q    <= q_nxt;
      bus.wrap <= tc_c;
    end
  end

  assign bus.tc   = tc_c;
  assign bus.qbar = ~bus.q;

endmodule
